// File: rtl/gsm_lcd_pkg.sv
// rtl/gsm_lcd_pkg.sv - shared constants, state encoding and slice helper for the GSM LCD line path
package gsm_lcd_pkg;

  localparam int         CHARS_DEF = 14;
  localparam logic [7:0] CR        = 8'h0D;
  localparam logic [7:0] LF        = 8'h0A;
  localparam logic [7:0] SPACE     = 8'h20;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    COLLECT = 2'd1,
    DISCARD = 2'd2
  } lb_state_t;

  // Character 0 sits in the most significant byte, so position i maps to this LSB.
  function automatic int char_lsb(input int i, input int chars);
    return (chars - 1 - i) * 8;
  endfunction

endpackage

// File: rtl/gsm_char_class.sv
// rtl/gsm_char_class.sv - combinational classification of a received byte
module gsm_char_class
  import gsm_lcd_pkg::*;
(
  input  logic [7:0] data,
  output logic       is_term,
  output logic       is_print
);

  // CR/LF end a line; 0x20..0x7E are kept; everything else is ignored upstream.
  always_comb begin
    is_term  = (data == CR) || (data == LF);
    is_print = (data >= 8'h20) && (data <= 8'h7E);
  end

endmodule

// File: rtl/gsm_line_buffer.sv
// rtl/gsm_line_buffer.sv - assembles UART text lines into a two-line LCD scroll
module gsm_line_buffer
  import gsm_lcd_pkg::*;
#(
  parameter int         CHARS = CHARS_DEF,
  parameter logic [7:0] PAD   = SPACE
) (
  input  logic                 CLOCK_50,
  input  logic                 iRST,
  input  logic [7:0]           iRX_DATA,
  input  logic                 iRX_VALID,
  input  logic                 iCLEAR,
  output logic [CHARS*8-1:0]   oLINE1,
  output logic [CHARS*8-1:0]   oLINE2,
  output logic                 oNEW_LINE,
  output logic                 oOVERFLOW
);

  localparam logic [3:0]         CNT_MAX   = 4'(CHARS);
  localparam logic [CHARS*8-1:0] PAD_LINE  = {CHARS{PAD}};

  lb_state_t           state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [CHARS*8-1:0]  line_buf_q, line_buf_d;
  logic [CHARS*8-1:0]  line1_q, line1_d;
  logic [CHARS*8-1:0]  line2_q, line2_d;
  logic                pulse_q, pulse_d;
  logic                ovf_q, ovf_d;
  logic                commit;
  logic                is_term;
  logic                is_print;

  gsm_char_class u_class (
    .data     (iRX_DATA),
    .is_term  (is_term),
    .is_print (is_print)
  );

  // State and output registers; reset leaves both lines blank and nothing pending.
  always_ff @(posedge CLOCK_50) begin
    if (iRST) begin
      state_q    <= EMPTY;
      cnt_q      <= 4'd0;
      line_buf_q <= PAD_LINE;
      line1_q    <= PAD_LINE;
      line2_q    <= PAD_LINE;
      pulse_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      line_buf_q <= line_buf_d;
      line1_q    <= line1_d;
      line2_q    <= line2_d;
      pulse_q    <= pulse_d;
      ovf_q      <= ovf_d;
    end
  end

  // Next-state: collect printable bytes, truncate long lines, scroll on a non-empty terminator.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    line_buf_d = line_buf_q;
    line1_d    = line1_q;
    line2_d    = line2_q;
    pulse_d    = 1'b0;
    ovf_d      = ovf_q;
    commit     = 1'b0;

    if (iCLEAR) begin
      state_d    = EMPTY;
      cnt_d      = 4'd0;
      line_buf_d = PAD_LINE;
      line1_d    = PAD_LINE;
      line2_d    = PAD_LINE;
      ovf_d      = 1'b0;
    end else if (iRX_VALID) begin
      case (state_q)
        EMPTY: begin
          // A terminator here would be a blank line, which is never shown.
          if (is_print) begin
            line_buf_d[char_lsb(0, CHARS) +: 8] = iRX_DATA;
            cnt_d   = 4'd1;
            state_d = COLLECT;
          end
        end
        COLLECT: begin
          if (is_print) begin
            if (cnt_q < CNT_MAX) begin
              line_buf_d[char_lsb(int'(cnt_q), CHARS) +: 8] = iRX_DATA;
              cnt_d = cnt_q + 4'd1;
            end else begin
              ovf_d   = 1'b1;
              state_d = DISCARD;
            end
          end else if (is_term) begin
            commit = 1'b1;
          end
        end
        DISCARD: begin
          if (is_term) begin
            commit = 1'b1;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end

    if (commit) begin
      line1_d = line2_q;
      for (int i = 0; i < CHARS; i++) begin
        line2_d[char_lsb(i, CHARS) +: 8] =
          (i < int'(cnt_q)) ? line_buf_q[char_lsb(i, CHARS) +: 8] : PAD;
      end
      line_buf_d = PAD_LINE;
      cnt_d      = 4'd0;
      state_d    = EMPTY;
      pulse_d    = 1'b1;
    end
  end

  assign oLINE1    = line1_q;
  assign oLINE2    = line2_q;
  assign oNEW_LINE = pulse_q;
  assign oOVERFLOW = ovf_q;

endmodule

// File: tb/tb_gsm_line_buffer.sv
// tb/tb_gsm_line_buffer.sv - randomized and directed self-checking bench for gsm_line_buffer
module tb_gsm_line_buffer;

  localparam int CHARS = 14;
  localparam int W     = CHARS * 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic         clr;
  logic [W-1:0] line1;
  logic [W-1:0] line2;
  logic         new_line;
  logic         overflow;

  int errors = 0;
  int checks = 0;
  int pulses = 0;

  // Reference model: a plain queue of every printable byte of the current line.
  logic [7:0]   q[$];
  logic [W-1:0] m_l1;
  logic [W-1:0] m_l2;
  logic         m_pulse;
  logic         m_ovf;

  gsm_line_buffer dut (
    .CLOCK_50  (clk),
    .iRST      (rst),
    .iRX_DATA  (rx_data),
    .iRX_VALID (rx_valid),
    .iCLEAR    (clr),
    .oLINE1    (line1),
    .oLINE2    (line2),
    .oNEW_LINE (new_line),
    .oOVERFLOW (overflow)
  );

  always #10 clk = ~clk;

  function automatic logic [W-1:0] lit(input string s);
    logic [W-1:0] r;
    for (int i = 0; i < CHARS; i++)
      r[(CHARS-1-i)*8 +: 8] = (i < s.len()) ? s[i] : 8'h20;
    return r;
  endfunction

  function automatic logic [W-1:0] model_line();
    logic [W-1:0] r;
    for (int i = 0; i < CHARS; i++)
      r[(CHARS-1-i)*8 +: 8] = (i < q.size()) ? q[i] : 8'h20;
    return r;
  endfunction

  task automatic chk_vec(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model update for what the coming rising edge must do.
  task automatic model_apply(input logic v, input logic [7:0] d, input logic c, input logic r);
    m_pulse = 1'b0;
    if (r || c) begin
      q.delete();
      m_l1  = lit("");
      m_l2  = lit("");
      m_ovf = 1'b0;
    end else if (v) begin
      if (d == 8'h0D || d == 8'h0A) begin
        if (q.size() > 0) begin
          m_l1 = m_l2;
          m_l2 = model_line();
          q.delete();
          m_pulse = 1'b1;
        end
      end else if (d >= 8'h20 && d <= 8'h7E) begin
        q.push_back(d);
        if (q.size() > CHARS) m_ovf = 1'b1;
      end
    end
  endtask

  // One clock: compare outputs at the falling edge, then drive the next inputs.
  task automatic cycle(input logic v, input logic [7:0] d, input logic c, input logic r);
    @(negedge clk);
    chk_vec("line1", line1, m_l1);
    chk_vec("line2", line2, m_l2);
    chk_bit("new_line", new_line, m_pulse);
    chk_bit("overflow", overflow, m_ovf);
    if (new_line) pulses++;
    rx_valid = v;
    rx_data  = d;
    clr      = c;
    rst      = r;
    model_apply(v, d, c, r);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) cycle(1'b1, s[i], 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  int p0;
  logic [7:0] rb;

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; clr = 1'b0;
    q.delete();
    m_l1 = lit(""); m_l2 = lit(""); m_pulse = 1'b0; m_ovf = 1'b0;
    repeat (2) @(posedge clk);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    idle(1);
    chk_vec("reset_line1", line1, lit(""));
    chk_vec("reset_line2", line2, lit(""));
    chk_bit("reset_overflow", overflow, 1'b0);

    p0 = pulses;
    send_str("OK\r\n");
    idle(2);
    chk_vec("ok_line2", line2, lit("OK"));
    chk_vec("ok_line1", line1, lit(""));
    chk_int("ok_pulses", pulses - p0, 1);

    send_str("+CSQ: 15,0\r\n");
    idle(2);
    chk_vec("csq_line1", line1, lit("OK"));
    chk_vec("csq_line2", line2, lit("+CSQ: 15,0"));

    p0 = pulses;
    send_str("ABCDEFGHIJKLMNOPQRST\r");
    idle(2);
    chk_vec("long_line2", line2, lit("ABCDEFGHIJKLMN"));
    chk_bit("long_overflow", overflow, 1'b1);
    chk_int("long_pulses", pulses - p0, 1);

    p0 = pulses;
    send_str("\r\n\r\n");
    cycle(1'b1, 8'h07, 1'b0, 1'b0);
    idle(2);
    chk_int("blank_pulses", pulses - p0, 0);
    chk_vec("blank_line2", line2, lit("ABCDEFGHIJKLMN"));
    chk_bit("overflow_sticky", overflow, 1'b1);

    cycle(1'b1, "A", 1'b0, 1'b0);
    cycle(1'b1, 8'h07, 1'b0, 1'b0);
    send_str("B\r");
    idle(2);
    chk_vec("ctrl_line2", line2, lit("AB"));

    send_str("AT");
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    idle(2);
    chk_vec("rst_line1", line1, lit(""));
    chk_vec("rst_line2", line2, lit(""));
    send_str("X\r");
    idle(2);
    chk_vec("x_line2", line2, lit("X"));
    chk_vec("x_line1", line1, lit(""));

    send_str("0123456789ABCDEF\r");
    send_str("HI");
    p0 = pulses;
    cycle(1'b1, 8'h0D, 1'b1, 1'b0);
    idle(2);
    chk_vec("clr_line1", line1, lit(""));
    chk_vec("clr_line2", line2, lit(""));
    chk_bit("clr_overflow", overflow, 1'b0);
    chk_int("clr_pulses", pulses - p0, 0);
    send_str("Z\r");
    idle(2);
    chk_vec("z_line2", line2, lit("Z"));

    for (int n = 0; n < 4000; n++) begin
      int sel;
      sel = int'($urandom_range(0, 99));
      if (sel < 50)      rb = 8'(8'h41 + $urandom_range(0, 25));
      else if (sel < 60) rb = 8'(8'h20 + $urandom_range(0, 94));
      else if (sel < 70) rb = ($urandom_range(0, 1) == 0) ? 8'h0D : 8'h0A;
      else               rb = 8'($urandom_range(0, 255));
      cycle(($urandom_range(0, 9) < 7), rb,
            ($urandom_range(0, 199) == 0), ($urandom_range(0, 399) == 0));
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gsm_line_buffer.md
# gsm_line_buffer

Sits directly upstream of the 16x2 LCD controller in the GSM_FPGA design. Consumes the byte stream received from the GSM modem's UART and assembles CR/LF-terminated text lines. Drives the controller's two 14-character line inputs as a two-line scroll: each completed line appears on line 2, and the previous line 2 moves to line 1. Empty lines and non-printable bytes are dropped, over-long lines are truncated, and short lines are padded with spaces.

## Interface
Parameters:
- CHARS, 14: characters per line; line ports are CHARS*8 bits wide.
- PAD, 8'h20: fill character for unused positions.

Ports:
- CLOCK_50  in  1: 50 MHz clock. It is the only clock; every register is on its rising edge.
- iRST  in  1: reset, synchronous and active-high.
- iRX_DATA  in  8: received byte from the UART receiver.
- iRX_VALID  in  1: one-cycle strobe; iRX_DATA is valid in that cycle. No backpressure; a byte is accepted in every cycle the strobe is high.
- iCLEAR  in  1: synchronous blank of both lines and the assembly buffer.
- oLINE1  out  CHARS*8: upper LCD line. Character 0 (leftmost) is in bits [CHARS*8-1 -: 8].
- oLINE2  out  CHARS*8: lower LCD line, same packing as oLINE1.
- oNEW_LINE  out  1: one-cycle pulse in the cycle after a commit.
- oOVERFLOW  out  1: sticky; a line exceeded CHARS characters since the last reset or clear.

## Operation
Byte classes:
- CR (8'h0D) and LF (8'h0A) are terminators.
- 8'h20..8'h7E are printable.
- All other bytes are ignored and leave no state change.

State machine:
- EMPTY: no characters collected.
  - Printable byte: write to buf[0], cnt=1, go to COLLECT.
  - Terminator: ignored. A blank line is never committed, so CR LF yields a single commit.
- COLLECT:
  - Printable byte with cnt<CHARS: write to buf[cnt], cnt+1.
  - Printable byte with cnt==CHARS: drop the byte, set oOVERFLOW, go to DISCARD.
  - Terminator: commit, then go to EMPTY.
- DISCARD:
  - Printable bytes: dropped.
  - Terminator: commit of the 14 retained characters, then go to EMPTY.

Commit:
- oLINE1 takes oLINE2.
- oLINE2 takes buf, with positions cnt..CHARS-1 forced to PAD.
- buf is refilled with PAD and cnt returns to 0.
- oNEW_LINE is asserted for the next cycle.

iCLEAR:
- oLINE1, oLINE2 and buf become all PAD; cnt=0; state EMPTY; oOVERFLOW=0.
- It has priority over iRX_VALID in the same cycle; that byte is lost.

Width rules: cnt is 4 bits, range 0..CHARS, and never wraps.

## Timing
- Reset values: oLINE1 and oLINE2 all PAD ("              "), oNEW_LINE=0, oOVERFLOW=0, state EMPTY, cnt=0, buf all PAD.
- A byte strobed in cycle k is applied at the edge ending cycle k.
- A terminator strobed in cycle k gives new oLINE1/oLINE2 values visible in cycle k+1, with oNEW_LINE=1 in cycle k+1 only.
- Back-to-back strobes are accepted every cycle. A printable byte directly after a terminator starts the next line with no bubble.
- oLINE1 and oLINE2 change only on commit, iCLEAR or reset. They are stable for the downstream LCD controller between those events.
- iRST mid-line discards the partial line; no commit and no pulse.
- Reset or clear during a terminator cycle: no commit.

## Structure
- Package gsm_lcd_pkg holds:
  - CHARS default, CR, LF and SPACE constants.
  - State encoding EMPTY/COLLECT/DISCARD.
  - A function giving the character slice index for position i.
- Sub-module gsm_char_class: purely combinational decode of iRX_DATA into is_term and is_print.
- Everything else (buffer, cnt, FSM, output registers) lives in gsm_line_buffer.

## Test plan
- Reset, then send "OK\r\n":
  - oLINE2 = "OK" plus 12 spaces, and oLINE1 = 14 spaces.
  - Exactly one oNEW_LINE pulse, one cycle after CR.
  - The following LF causes nothing.
- Then send "+CSQ: 15,0\r\n":
  - oLINE1 = "OK" plus 12 spaces.
  - oLINE2 = "+CSQ: 15,0" plus 4 spaces.
- Send a 20-char line "ABCDEFGHIJKLMNOPQRST\r":
  - oLINE2 = "ABCDEFGHIJKLMN" and oOVERFLOW=1 and stays 1.
  - Exactly one pulse.
- Send "\r\n\r\n" and an isolated 8'h07:
  - No output change and no pulse.
  - "A",8'h07,"B\r" gives "AB" plus 12 spaces.
- Send "AT" with iRST asserted one cycle, then "X\r":
  - After reset, both lines are blank.
  - After "X\r", oLINE2 = "X" plus 13 spaces; "AT" is not present.
- Assert iCLEAR in the same cycle as a CR strobe after "HI":
  - Both lines are blank, with no pulse and oOVERFLOW=0.
  - A following "Z\r" commits "Z" plus 13 spaces.
